// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner arbitration for a shared AHB-style system bus.
// One owner at a time drives the slave side. Ready and response are routed back
// to the owner only. Ownership ends with one idle GAP cycle. A stall watchdog
// forces an error and release when the slave holds hready low for too long.
module bus_arbiter #(
  parameter  int N_MASTER  = 3,
  parameter  int BUS_WIDTH = 8,
  parameter  int BUS_ADDR  = 24,
  parameter  int TIMEOUT   = 256,
  localparam int OW        = $clog2(N_MASTER)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTER-1:0]           m_req,
  output logic [N_MASTER-1:0]           m_ack,
  input  logic [N_MASTER*BUS_ADDR-1:0]  m_haddr,
  input  logic [N_MASTER-1:0]           m_hwrite,
  input  logic [N_MASTER-1:0]           m_hburst,
  input  logic [N_MASTER-1:0]           m_htrans,
  input  logic [N_MASTER*BUS_WIDTH-1:0] m_hwdata,
  output logic [N_MASTER-1:0]           m_hready,
  output logic [N_MASTER-1:0]           m_hresp,
  output logic [BUS_ADDR-1:0]           s_haddr,
  output logic                          s_hwrite,
  output logic                          s_hburst,
  output logic                          s_htrans,
  output logic [BUS_WIDTH-1:0]          s_hwdata,
  input  logic                          s_hready,
  input  logic                          s_hresp,
  output logic [OW-1:0]                 owner,
  output logic                          timeout_err
);

  // A disabled watchdog still keeps a 1-bit counter so no zero-width vector exists.
  localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SW-1:0] STALL_MAX  = '1;
  localparam logic [OW-1:0] LAST_IDX   = OW'(N_MASTER - 1);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t               state_q;
  logic [OW-1:0]        owner_q;
  logic [OW-1:0]        rr_q;
  logic [N_MASTER-1:0]  ack_q;
  logic [SW-1:0]        stall_q;
  logic [SW-1:0]        stall_d;

  logic                 own_w;
  logic                 release_w;
  logic                 wd_fire;
  logic                 grant_found;
  logic [OW-1:0]        grant_idx;
  logic [OW-1:0]        rr_next;

  logic [BUS_ADDR-1:0]  addr_arr  [N_MASTER];
  logic [BUS_WIDTH-1:0] wdata_arr [N_MASTER];

  // Unpack the flat per-master buses and route ready/response to the owner bit only.
  generate
    for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_master
      assign addr_arr[gi]  = m_haddr[gi*BUS_ADDR +: BUS_ADDR];
      assign wdata_arr[gi] = m_hwdata[gi*BUS_WIDTH +: BUS_WIDTH];
      assign m_hready[gi]  = ack_q[gi] & s_hready;
      assign m_hresp[gi]   = ack_q[gi] & (s_hresp | wd_fire);
    end
  endgenerate

  assign own_w     = (state_q == OWN);
  assign release_w = own_w & ~m_req[owner_q] & ~m_htrans[owner_q] & s_hready;
  assign wd_fire   = (TIMEOUT != 0) && own_w && !s_hready && (stall_q == STALL_LAST);
  assign rr_next   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  // Round-robin search starting at rr_q; walking offsets downward leaves the nearest requester.
  always_comb begin
    int idx;
    logic [OW-1:0] idx_v;
    grant_found = 1'b0;
    grant_idx   = rr_q;
    idx         = 0;
    idx_v       = '0;
    for (int k = N_MASTER - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= N_MASTER) idx = idx - N_MASTER;
      idx_v = OW'(idx);
      if (m_req[idx_v]) begin
        grant_found = 1'b1;
        grant_idx   = idx_v;
      end
    end
  end

  // Ownership state machine: IDLE grants, OWN holds until release or watchdog, GAP idles one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      ack_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            owner_q <= grant_idx;
            ack_q   <= {{(N_MASTER-1){1'b0}}, 1'b1} << grant_idx;
            state_q <= OWN;
          end
        end
        OWN: begin
          if (release_w || wd_fire) begin
            rr_q    <= rr_next;
            ack_q   <= '0;
            state_q <= GAP;
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall counter: counts owned cycles with hready low, saturating so it never wraps.
  always_comb begin
    stall_d = stall_q;
    if (!own_w || s_hready) stall_d = '0;
    else if (stall_q != STALL_MAX) stall_d = stall_q + 1'b1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  // Slave-side mux: the owner's request signals while owned, all zero otherwise.
  always_comb begin
    s_haddr  = '0;
    s_hwdata = '0;
    s_hwrite = 1'b0;
    s_hburst = 1'b0;
    s_htrans = 1'b0;
    if (own_w) begin
      s_haddr  = addr_arr[owner_q];
      s_hwdata = wdata_arr[owner_q];
      s_hwrite = m_hwrite[owner_q];
      s_hburst = m_hburst[owner_q];
      s_htrans = m_htrans[owner_q];
    end
  end

  assign m_ack       = ack_q;
  assign owner       = owner_q;
  assign timeout_err = wd_fire;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: vector-table and scoreboard bench for bus_arbiter.
module tb_bus_arbiter;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] htrans;
    logic       hready;
    logic       hresp;
    logic [2:0] ack;
    logic [1:0] own;
    logic [2:0] mhr;
    logic [2:0] mhs;
    logic       terr;
    logic       sht;
    int         sel;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  m_req = '0;
  logic [2:0]  m_htrans = '0;
  logic [2:0]  m_hwrite = 3'b101;
  logic [2:0]  m_hburst = 3'b110;
  logic [71:0] m_haddr = '0;
  logic [23:0] m_hwdata = '0;
  logic        s_hready = 1'b1;
  logic        s_hresp = 1'b0;

  logic [2:0]  m_ack, m_hready, m_hresp;
  logic [23:0] s_haddr;
  logic        s_hwrite, s_hburst, s_htrans;
  logic [7:0]  s_hwdata;
  logic [1:0]  owner;
  logic        timeout_err;

  logic [2:0]  nw_ack, nw_hready, nw_hresp;
  logic [23:0] nw_haddr;
  logic        nw_hwrite, nw_hburst, nw_htrans;
  logic [7:0]  nw_hwdata;
  logic [1:0]  nw_owner;
  logic        nw_terr;

  logic [23:0] addr_tab [3];
  logic [7:0]  data_tab [3];
  vec_t        vecs [$];
  vec_t        exp_q [$];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.N_MASTER(3), .BUS_WIDTH(8), .BUS_ADDR(24), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_ack(m_ack), .m_haddr(m_haddr),
    .m_hwrite(m_hwrite), .m_hburst(m_hburst), .m_htrans(m_htrans), .m_hwdata(m_hwdata),
    .m_hready(m_hready), .m_hresp(m_hresp), .s_haddr(s_haddr), .s_hwrite(s_hwrite),
    .s_hburst(s_hburst), .s_htrans(s_htrans), .s_hwdata(s_hwdata), .s_hready(s_hready),
    .s_hresp(s_hresp), .owner(owner), .timeout_err(timeout_err)
  );

  bus_arbiter #(.N_MASTER(3), .BUS_WIDTH(8), .BUS_ADDR(24), .TIMEOUT(0)) dut_nw (
    .clk(clk), .rst(rst), .m_req(m_req), .m_ack(nw_ack), .m_haddr(m_haddr),
    .m_hwrite(m_hwrite), .m_hburst(m_hburst), .m_htrans(m_htrans), .m_hwdata(m_hwdata),
    .m_hready(nw_hready), .m_hresp(nw_hresp), .s_haddr(nw_haddr), .s_hwrite(nw_hwrite),
    .s_hburst(nw_hburst), .s_htrans(nw_htrans), .s_hwdata(nw_hwdata), .s_hready(s_hready),
    .s_hresp(s_hresp), .owner(nw_owner), .timeout_err(nw_terr)
  );

  function automatic void chk(input int id, input string what, input logic [31:0] got,
                              input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %0h expected %0h", id, what, got, want);
    end
  endfunction

  function automatic void add(input logic r, input logic [2:0] rq, input logic [2:0] ht,
                              input logic hr, input logic hs, input logic [2:0] ack,
                              input logic [1:0] own, input logic [2:0] mhr,
                              input logic [2:0] mhs, input logic terr, input logic sht,
                              input int sel);
    vec_t v;
    v.rst = r; v.req = rq; v.htrans = ht; v.hready = hr; v.hresp = hs;
    v.ack = ack; v.own = own; v.mhr = mhr; v.mhs = mhs; v.terr = terr; v.sht = sht;
    v.sel = sel;
    vecs.push_back(v);
  endfunction

  initial begin
    vec_t e;
    int order [5];
    logic [2:0] oh;
    logic [1:0] last;
    logic [23:0] exp_addr;
    logic [7:0] exp_data;
    logic exp_w, exp_b;

    order = '{0, 1, 2, 0, 1};
    addr_tab[0] = 24'h10A1A1; addr_tab[1] = 24'h20B2B2; addr_tab[2] = 24'h30C3C3;
    data_tab[0] = 8'hA1; data_tab[1] = 8'hB2; data_tab[2] = 8'hC3;
    m_haddr  = {addr_tab[2], addr_tab[1], addr_tab[0]};
    m_hwdata = {data_tab[2], data_tab[1], data_tab[0]};

    // single master 0 tenure from reset
    add(0, 3'b001, 3'b000, 1, 0, 3'b000, 0, 3'b000, 3'b000, 0, 0, -1);
    add(0, 3'b001, 3'b001, 1, 0, 3'b001, 0, 3'b001, 3'b000, 0, 1, 0);
    add(0, 3'b001, 3'b001, 1, 0, 3'b001, 0, 3'b001, 3'b000, 0, 1, 0);
    add(0, 3'b000, 3'b000, 1, 0, 3'b001, 0, 3'b001, 3'b000, 0, 0, 0);
    add(0, 3'b000, 3'b000, 1, 0, 3'b000, 0, 3'b000, 3'b000, 0, 0, -1);
    add(0, 3'b000, 3'b000, 1, 0, 3'b000, 0, 3'b000, 3'b000, 0, 0, -1);
    // round robin with all three requesting
    add(1, 3'b000, 3'b000, 1, 0, 3'b000, 0, 3'b000, 3'b000, 0, 0, -1);
    last = 2'd0;
    for (int k = 0; k < 5; k++) begin
      oh = 3'b001 << order[k];
      add(0, 3'b111, 3'b000, 1, 0, 3'b000, last, 3'b000, 3'b000, 0, 0, -1);
      add(0, 3'b111, oh, 1, 0, oh, 2'(order[k]), oh, 3'b000, 0, 1, order[k]);
      add(0, 3'b111 & ~oh, 3'b000, 1, 0, oh, 2'(order[k]), oh, 3'b000, 0, 0, order[k]);
      add(0, 3'b111, 3'b000, 1, 0, 3'b000, 2'(order[k]), 3'b000, 3'b000, 0, 0, -1);
      last = 2'(order[k]);
    end
    // watchdog on master 1, TIMEOUT=16
    add(1, 3'b000, 3'b000, 1, 0, 3'b000, 1, 3'b000, 3'b000, 0, 0, -1);
    add(0, 3'b010, 3'b000, 1, 0, 3'b000, 0, 3'b000, 3'b000, 0, 0, -1);
    for (int s = 1; s <= 16; s++)
      add(0, 3'b010, 3'b010, 0, 0, 3'b010, 1, 3'b000, (s == 16) ? 3'b010 : 3'b000,
          (s == 16), 1, 1);
    add(0, 3'b000, 3'b000, 0, 0, 3'b000, 1, 3'b000, 3'b000, 0, 0, -1);
    add(0, 3'b000, 3'b000, 1, 0, 3'b000, 1, 3'b000, 3'b000, 0, 0, -1);
    // master 2 with slave error and non-owner htrans
    add(0, 3'b100, 3'b000, 1, 0, 3'b000, 1, 3'b000, 3'b000, 0, 0, -1);
    add(0, 3'b100, 3'b011, 1, 1, 3'b100, 2, 3'b100, 3'b100, 0, 0, 2);
    add(0, 3'b100, 3'b111, 1, 1, 3'b100, 2, 3'b100, 3'b100, 0, 1, 2);
    add(0, 3'b100, 3'b100, 0, 0, 3'b100, 2, 3'b000, 3'b000, 0, 1, 2);
    add(0, 3'b000, 3'b000, 1, 0, 3'b100, 2, 3'b100, 3'b000, 0, 0, 2);
    add(0, 3'b000, 3'b000, 1, 0, 3'b000, 2, 3'b000, 3'b000, 0, 0, -1);
    add(0, 3'b000, 3'b000, 1, 0, 3'b000, 2, 3'b000, 3'b000, 0, 0, -1);
    // reset during master 1 burst, then first grant with 110
    add(0, 3'b010, 3'b000, 1, 0, 3'b000, 2, 3'b000, 3'b000, 0, 0, -1);
    add(0, 3'b010, 3'b010, 1, 0, 3'b010, 1, 3'b010, 3'b000, 0, 1, 1);
    add(1, 3'b010, 3'b010, 1, 0, 3'b010, 1, 3'b010, 3'b000, 0, 1, 1);
    add(0, 3'b110, 3'b000, 1, 0, 3'b000, 0, 3'b000, 3'b000, 0, 0, -1);
    add(0, 3'b110, 3'b010, 1, 0, 3'b010, 1, 3'b010, 3'b000, 0, 1, 1);
    add(0, 3'b100, 3'b000, 1, 0, 3'b010, 1, 3'b010, 3'b000, 0, 0, 1);
    add(0, 3'b100, 3'b000, 1, 0, 3'b000, 1, 3'b000, 3'b000, 0, 0, -1);
    add(0, 3'b100, 3'b000, 1, 0, 3'b000, 1, 3'b000, 3'b000, 0, 0, -1);
    add(0, 3'b100, 3'b100, 1, 0, 3'b100, 2, 3'b100, 3'b000, 0, 1, 2);
    add(0, 3'b000, 3'b000, 1, 0, 3'b100, 2, 3'b100, 3'b000, 0, 0, 2);
    add(0, 3'b000, 3'b000, 1, 0, 3'b000, 2, 3'b000, 3'b000, 0, 0, -1);

    repeat (3) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; m_req = vecs[i].req; m_htrans = vecs[i].htrans;
      s_hready = vecs[i].hready; s_hresp = vecs[i].hresp;
      exp_q.push_back(vecs[i]);
      #2;
      e = exp_q.pop_front();
      exp_addr = (e.sel >= 0) ? addr_tab[e.sel] : 24'h0;
      exp_data = (e.sel >= 0) ? data_tab[e.sel] : 8'h0;
      exp_w    = (e.sel >= 0) ? m_hwrite[e.sel] : 1'b0;
      exp_b    = (e.sel >= 0) ? m_hburst[e.sel] : 1'b0;
      chk(i, "m_ack", 32'(m_ack), 32'(e.ack));
      chk(i, "owner", 32'(owner), 32'(e.own));
      chk(i, "m_hready", 32'(m_hready), 32'(e.mhr));
      chk(i, "m_hresp", 32'(m_hresp), 32'(e.mhs));
      chk(i, "timeout_err", 32'(timeout_err), 32'(e.terr));
      chk(i, "s_htrans", 32'(s_htrans), 32'(e.sht));
      chk(i, "s_haddr", 32'(s_haddr), 32'(exp_addr));
      chk(i, "s_hwdata", 32'(s_hwdata), 32'(exp_data));
      chk(i, "s_hwrite", 32'(s_hwrite), 32'(exp_w));
      chk(i, "s_hburst", 32'(s_hburst), 32'(exp_b));
      $display("vec%0d rst=%b req=%b ack=%b owner=%0d terr=%b", i, vecs[i].rst,
               vecs[i].req, m_ack, owner, timeout_err);
    end

    // watchdog disabled: a 1000-cycle stall keeps ownership with no error
    @(negedge clk);
    rst = 1'b1; m_req = 3'b000; m_htrans = 3'b000; s_hready = 1'b1; s_hresp = 1'b0;
    @(negedge clk);
    rst = 1'b0; m_req = 3'b001; m_htrans = 3'b001; s_hready = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      #2;
      chk(1000 + c, "nowd timeout_err", 32'(nw_terr), 32'd0);
      chk(1000 + c, "nowd m_ack", 32'(nw_ack), 32'd1);
    end
    $display("nowd stall 1000 cycles: ack=%b terr=%b", nw_ack, nw_terr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
